// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit for the execute stage.
//
// A request is accepted with a one-cycle `start` pulse while idle. The
// operands are latched, reduced to magnitudes, and processed one bit per
// cycle for 32 cycles (radix-2 shift-add multiply or restoring divide).
// The sign is fixed up on the cycle that enters DONE, where `result` is
// registered and `done` pulses for one cycle. `result` is then held until
// the next request completes.
//
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous, active-high; aborts any request in progress
//   start   - request pulse, honoured only in IDLE
//   op      - RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b    - rs1 / rs2 operands
//   busy    - request in progress
//   done    - one-cycle pulse, `result` valid
//   result  - final value
//
// Build option:
//   MULDIV_EARLY_OUT_EN - when defined, divide-by-zero and signed-overflow
//   requests skip the 32 iteration cycles and complete one cycle after
//   accept. Otherwise they take the normal latency with the same values.

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          neg_q, neg_d;
  logic          special_q, special_d;
  logic [31:0]   spec_res_q, spec_res_d;
  // Multiply: addend magnitude of a. Divide: divisor magnitude of b.
  logic [31:0]   opnd_q, opnd_d;
  // Multiply: {product high, multiplier/product low}.
  // Divide:   {partial remainder, dividend/quotient}.
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   result_q, result_d;

  logic          a_sgn, b_sgn, div0, ovf;
  logic [31:0]   mag_a, mag_b;
  logic [32:0]   mul_hi;
  logic [32:0]   div_shift;
  logic [33:0]   div_diff;

  // Sign fix-up and result selection once the iterations are finished.
  function automatic logic [31:0] final_result(
    input logic [2:0]  f_op,
    input logic        f_neg,
    input logic        f_special,
    input logic [31:0] f_spec_res,
    input logic [63:0] f_acc
  );
    logic [63:0] full;
    logic [31:0] sel;
    if (f_special) begin
      return f_spec_res;
    end
    if (!f_op[2]) begin
      full = f_neg ? (~f_acc + 64'd1) : f_acc;
      return (f_op[1:0] == 2'b00) ? full[31:0] : full[63:32];
    end
    sel = f_op[1] ? f_acc[63:32] : f_acc[31:0];
    return f_neg ? (~sel + 32'd1) : sel;
  endfunction

  // Accept-time operand conditioning
  always_comb begin
    a_sgn = a[31] && (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    b_sgn = b[31] && (op == 3'b001 || op == 3'b100 || op == 3'b110);
    mag_a = a_sgn ? (~a + 32'd1) : a;
    mag_b = b_sgn ? (~b + 32'd1) : b;
    div0  = op[2] && (b == 32'd0);
    ovf   = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  end

  // Iteration datapath
  always_comb begin
    mul_hi    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_d      = neg_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    result_d   = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CALC;
          op_d       = op;
          // Remainder follows the dividend; everything else is the XOR.
          neg_d      = (op[2] && op[1]) ? a_sgn : (a_sgn ^ b_sgn);
          special_d  = div0 || ovf;
          spec_res_d = div0 ? (op[1] ? a : 32'hFFFF_FFFF)
                            : (op[1] ? 32'd0 : 32'h8000_0000);
          opnd_d     = op[2] ? mag_b : mag_a;
          acc_d      = {32'd0, op[2] ? mag_a : mag_b};
`ifdef MULDIV_EARLY_OUT_EN
          // Preloading the terminal count makes the next edge finish.
          cnt_d      = (div0 || ovf) ? 6'd32 : 6'd0;
`else
          cnt_d      = 6'd0;
`endif
        end
      end
      CALC: begin
        if (cnt_q[5]) begin
          state_d  = DONE;
          cnt_d    = 6'd0;
          result_d = final_result(op_q, neg_q, special_q, spec_res_q, acc_q);
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (!op_q[2]) begin
            acc_d = {mul_hi, acc_q[31:1]};
          end else if (!div_diff[33]) begin
            acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Operand/accumulator registers carry no reset; they are loaded on accept.
  always_ff @(posedge clk) begin
    op_q       <= op_d;
    neg_q      <= neg_d;
    special_q  <= special_d;
    spec_res_q <= spec_res_d;
    opnd_q     <= opnd_d;
    acc_q      <= acc_d;
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
